axil_cfg_loader: RTL and testbench

//  AXI4-Lite master sitting directly upstream of the ten_reg_map register slave. On a start

---
 rtl/axil_cfg_pkg.sv | 12 +
 rtl/axil_cfg_loader.sv | 251 +++++++++++++++++++++++++
 tb/tb_axil_cfg_loader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_cfg_pkg.sv
// axil_cfg_pkg: shared state encoding and error codes for the AXI4-Lite config loader
package axil_cfg_pkg;

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, FINISH} state_t;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_RESP      = 2'd1;
    localparam logic [1:0] ERR_DATA      = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd3;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/axil_cfg_loader.sv
// axil_cfg_loader: AXI4-Lite master that writes a register image and optionally reads it back
module axil_cfg_loader
    import axil_cfg_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS = 10,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            start,
    input  logic                            verify_en,
    input  logic [NUM_REGS*32-1:0]          cfg_data,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [1:0]                      err_code,
    output logic [3:0]                      err_index,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                 state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic [NUM_REGS*32-1:0] words_q, words_d;
    logic                   verify_q, verify_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                   aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                   bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic                   busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [1:0]             err_code_q, err_code_d;
    logic [3:0]             err_index_q, err_index_d;
    logic                   fail, fin, timeout, last;
    logic [1:0]             fail_code;
    logic [31:0]            cur_word;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr;

    assign cur_word = words_q[{idx_q, 5'd0} +: 32];
    assign addr     = BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx_q, 2'b00});
    assign timeout  = timer_q == TW'(TIMEOUT_CYCLES);
    assign last     = idx_q == 4'(NUM_REGS - 1);

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = err_code_q;
    assign err_index     = err_index_q;
    assign M_AXI_AWADDR  = addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = cur_word;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

    // Sequencer next-state: one transaction at a time, any error or timeout aborts to FINISH
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        words_d     = words_q;
        verify_d    = verify_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        err_code_d  = err_code_q;
        err_index_d = err_index_q;
        fail        = 1'b0;
        fail_code   = ERR_NONE;
        fin         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    words_d     = cfg_data;
                    verify_d    = verify_en;
                    error_d     = 1'b0;
                    err_code_d  = ERR_NONE;
                    err_index_d = '0;
                    idx_d       = '0;
                    busy_d      = 1'b1;
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    state_d     = WR;
                end
            end
            WR: begin
                awvalid_d = awvalid_q & ~M_AXI_AWREADY;
                wvalid_d  = wvalid_q & ~M_AXI_WREADY;
                aw_done_d = aw_done_q | (awvalid_q & M_AXI_AWREADY);
                w_done_d  = w_done_q | (wvalid_q & M_AXI_WREADY);
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end else if (timeout) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    bready_d = 1'b0;
                    if (M_AXI_BRESP != AXI_RESP_OKAY) begin
                        fail      = 1'b1;
                        fail_code = ERR_RESP;
                    end else if (last && verify_q) begin
                        idx_d     = '0;
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end else if (last) begin
                        fin = 1'b1;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR;
                    end
                end else if (timeout) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end else if (timeout) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rready_d = 1'b0;
                    if (M_AXI_RRESP != AXI_RESP_OKAY) begin
                        fail      = 1'b1;
                        fail_code = ERR_RESP;
                    end else if (M_AXI_RDATA != cur_word) begin
                        fail      = 1'b1;
                        fail_code = ERR_DATA;
                    end else if (last) begin
                        fin = 1'b1;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end else if (timeout) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (fail) begin
            error_d     = 1'b1;
            err_code_d  = fail_code;
            err_index_d = idx_q;
        end
        if (fail || fin) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = FINISH;
        end
        timer_d = (state_d != state_q) ? '0 : timer_q + TW'(1);
    end

    // State registers; reset drops every VALID/READY immediately without waiting for the slave
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            words_q     <= '0;
            verify_q    <= 1'b0;
            timer_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_index_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            words_q     <= words_d;
            verify_q    <= verify_d;
            timer_q     <= timer_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            err_index_q <= err_index_d;
        end
    end

endmodule

// File: tb/tb_axil_cfg_loader.sv
// tb_axil_cfg_loader: directed tests of the config loader against a behavioural register slave
module tb_axil_cfg_loader;

    logic          ACLK = 1'b0;
    logic          ARESET, start, verify_en;
    logic [319:0]  cfg_data;
    logic          busy, done, error;
    logic [1:0]    err_code;
    logic [3:0]    err_index;
    logic [31:0]   awaddr, wdata, araddr, rdata;
    logic [2:0]    awprot, arprot;
    logic [3:0]    wstrb;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [1:0]    bresp, rresp;

    int n_checks = 0;
    int n_fail = 0;

    always #5 ACLK = ~ACLK;

    axil_cfg_loader #(.TIMEOUT_CYCLES(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .verify_en(verify_en),
        .cfg_data(cfg_data), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .err_index(err_index),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
        .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    // Behavioural register slave with fault knobs and protocol monitors
    logic [31:0] mem [16];
    logic [15:0] wr_mask;
    int          wr_count, rd_count, aw_cnt;
    int          aw_stall = 0, bad_b_idx = -1, corrupt_idx = -1;
    logic        ar_block = 1'b0, clr_log = 1'b0;
    logic        aw_got, w_got, aw_wait, aw_unstable, w_first;
    logic [3:0]  aw_idx;
    logic [31:0] w_dat, last_aw;

    assign awready = awvalid && !aw_got && (aw_cnt >= aw_stall);
    assign wready  = wvalid && !w_got;
    assign arready = arvalid && !ar_block && !rvalid;
    assign rresp   = 2'b00;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            bvalid  <= 1'b0;
            rvalid  <= 1'b0;
            aw_cnt  <= 0;
            aw_wait <= 1'b0;
        end else begin
            aw_wait <= awvalid && !awready;
            last_aw <= awaddr;
            if (aw_wait && (!awvalid || awaddr != last_aw)) aw_unstable <= 1'b1;
            if (awvalid && !wvalid) w_first <= 1'b1;
            if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
            if (awready) begin
                aw_got <= 1'b1;
                aw_idx <= awaddr[5:2];
                aw_cnt <= 0;
            end
            if (wready) begin
                w_got <= 1'b1;
                w_dat <= wdata;
            end
            if (aw_got && w_got && !bvalid) begin
                bvalid <= 1'b1;
                if (int'(aw_idx) == bad_b_idx) bresp <= 2'b10;
                else begin
                    bresp            <= 2'b00;
                    mem[aw_idx]      <= w_dat;
                    wr_mask[aw_idx]  <= 1'b1;
                    wr_count         <= wr_count + 1;
                end
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (arready) begin
                rvalid   <= 1'b1;
                rdata    <= (int'(araddr[5:2]) == corrupt_idx) ? 32'hDEADBEEF : mem[araddr[5:2]];
                rd_count <= rd_count + 1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
        if (clr_log) begin
            wr_mask     <= '0;
            wr_count    <= 0;
            rd_count    <= 0;
            aw_unstable <= 1'b0;
            w_first     <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [31:0] base);
        for (int i = 0; i < 10; i++) cfg_data[32*i +: 32] = base + 32'(i);
    endtask

    task automatic clear_log();
        clr_log = 1'b1;
        @(negedge ACLK);
        clr_log = 1'b0;
    endtask

    task automatic do_start(input logic v);
        start     = 1'b1;
        verify_en = v;
        @(negedge ACLK);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done();
        int k = 0;
        while (done !== 1'b1 && k < 2000) begin
            @(negedge ACLK);
            k++;
        end
        check("done_seen", done, 1'b1);
        check("busy_at_done", busy, 1'b0);
    endtask

    task automatic check_mem(input logic [31:0] base);
        for (int i = 0; i < 10; i++) check("mem_word", mem[i], base + 32'(i));
    endtask

    initial begin
        int k;
        ARESET    = 1'b1;
        start     = 1'b0;
        verify_en = 1'b0;
        cfg_data  = '0;
        repeat (3) @(negedge ACLK);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_err_code", err_code, 2'd0);
        check("rst_err_index", err_index, 4'd0);
        check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        ARESET = 1'b0;
        clear_log();

        // 1: clean write + verify; a second start while busy with other data is ignored
        set_cfg(32'h1);
        do_start(1'b1);
        check("awprot_wstrb", {awprot, arprot, wstrb}, {3'b0, 3'b0, 4'hF});
        repeat (3) @(negedge ACLK);
        set_cfg(32'h5555_0000);
        start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        wait_done();
        check("t1_error", error, 1'b0);
        check("t1_err_code", err_code, 2'd0);
        check("t1_wr_count", wr_count, 10);
        check("t1_rd_count", rd_count, 10);
        check("t1_wr_mask", wr_mask, 16'h03FF);
        check_mem(32'h1);
        @(negedge ACLK);
        check("t1_done_one_cycle", done, 1'b0);

        // 2: AWREADY stalled 5 cycles while W completes at once
        clear_log();
        aw_stall = 5;
        set_cfg(32'hA0);
        do_start(1'b1);
        wait_done();
        check("t2_error", error, 1'b0);
        check("t2_w_first", w_first, 1'b1);
        check("t2_aw_stable", aw_unstable, 1'b0);
        check("t2_wr_count", wr_count, 10);
        check_mem(32'hA0);
        aw_stall = 0;

        // 3: SLVERR on register 3 aborts the write pass
        clear_log();
        bad_b_idx = 3;
        set_cfg(32'hB0);
        do_start(1'b1);
        wait_done();
        check("t3_error", error, 1'b1);
        check("t3_err_code", err_code, 2'd1);
        check("t3_err_index", err_index, 4'd3);
        check("t3_wr_mask", wr_mask, 16'h0007);
        check("t3_rd_count", rd_count, 0);
        bad_b_idx = -1;

        // 4: readback of register 7 corrupted
        clear_log();
        corrupt_idx = 7;
        set_cfg(32'hC0);
        do_start(1'b1);
        wait_done();
        check("t4_error", error, 1'b1);
        check("t4_err_code", err_code, 2'd2);
        check("t4_err_index", err_index, 4'd7);
        check("t4_wr_mask", wr_mask, 16'h03FF);
        check("t4_rd_count", rd_count, 8);
        corrupt_idx = -1;

        // 5: ARREADY never comes; timeout fires 17 cycles after ARVALID rises
        clear_log();
        ar_block = 1'b1;
        set_cfg(32'hD0);
        do_start(1'b1);
        k = 0;
        while (arvalid !== 1'b1 && k < 500) begin
            @(negedge ACLK);
            k++;
        end
        check("t5_arvalid_seen", arvalid, 1'b1);
        k = 0;
        while (error !== 1'b1 && k < 100) begin
            @(negedge ACLK);
            k++;
        end
        check("t5_timeout_latency", k, 17);
        check("t5_err_code", err_code, 2'd3);
        check("t5_err_index", err_index, 4'd0);
        check("t5_arvalid_dropped", arvalid, 1'b0);
        check("t5_done", done, 1'b1);
        check("t5_rd_count", rd_count, 0);
        ar_block = 1'b0;
        @(negedge ACLK);

        // 6: reset mid-write at index 4, then restart immediately without verify
        set_cfg(32'hE0);
        do_start(1'b0);
        k = 0;
        while (!(awvalid === 1'b1 && awaddr === 32'h10) && k < 500) begin
            @(negedge ACLK);
            k++;
        end
        check("t6_reached_idx4", awaddr, 32'h10);
        ARESET = 1'b1;
        @(negedge ACLK);
        check("t6_valids_dropped", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_done", done, 1'b0);
        ARESET = 1'b0;
        clear_log();
        set_cfg(32'hF0);
        do_start(1'b0);
        wait_done();
        check("t6_error", error, 1'b0);
        check("t6_wr_count", wr_count, 10);
        check("t6_rd_count", rd_count, 0);
        check_mem(32'hF0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
